mpi_eth_pkt_gen: RTL and testbench

//  Parametrised MPI-over-Ethernet packet generator. It turns one header request
//  (MAC/IP/rank/type/tag/size fields) plus a payload stream into one AXI-Stream

---
 rtl/mpi_eth_pkt_gen.sv | 224 ++++++++++++++++++++++
 tb/tb_mpi_eth_pkt_gen.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mpi_eth_pkt_gen.sv
// -----------------------------------------------------------------------------
// mpi_eth_pkt_gen
//
// Purpose:
//   MPI-over-Ethernet packet generator. One accepted header request, plus a
//   payload stream, becomes one AXI-Stream packet. The packet is a fixed
//   256-bit header followed by `size` payload bytes, cut into DATA_W-bit beats.
//   Requests larger than MAX_BYTES are rejected with a one-cycle err_size pulse.
//   A pay_LAST that disagrees with the byte count gives a one-cycle err_len
//   pulse. The packet length always follows `size`, never pay_LAST.
//
// Parameters:
//   DATA_W     beat width in bits (64, 128 or 256)
//   MAX_BYTES  largest payload size accepted, in bytes
//   CNT_W      width of the sent-packet counter
//
// Ports:
//   clk, resetn                   clock; asynchronous active-low reset
//   hdr_valid / hdr_ready         header request handshake; hdr_ready means idle
//   mac_dst .. size               header request fields
//   pay_DATA/KEEP/LAST/VALID      payload input stream; pay_KEEP is ignored
//   pay_READY                     payload ready
//   stream_out_*                  packet output stream (AXI-Stream)
//   err_size, err_len             one-cycle error pulses
//   pkt_count                     number of packets fully sent (wraps)
// -----------------------------------------------------------------------------
module mpi_eth_pkt_gen #(
  parameter int DATA_W    = 64,
  parameter int MAX_BYTES = 9000,
  parameter int CNT_W     = 32
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                hdr_valid,
  output logic                hdr_ready,
  input  logic [47:0]         mac_dst,
  input  logic [47:0]         mac_src,
  input  logic [31:0]         ip_src,
  input  logic [31:0]         ip_dst,
  input  logic [15:0]         dst,
  input  logic [15:0]         dst_rank,
  input  logic [7:0]          src_rank,
  input  logic [7:0]          packet_type,
  input  logic [7:0]          tag,
  input  logic [31:0]         size,
  input  logic [DATA_W-1:0]   pay_DATA,
  input  logic [DATA_W/8-1:0] pay_KEEP,
  input  logic                pay_LAST,
  input  logic                pay_VALID,
  output logic                pay_READY,
  output logic [DATA_W-1:0]   stream_out_DATA,
  output logic [DATA_W/8-1:0] stream_out_KEEP,
  output logic                stream_out_LAST,
  output logic                stream_out_VALID,
  input  logic                stream_out_READY,
  output logic                err_size,
  output logic                err_len,
  output logic [CNT_W-1:0]    pkt_count
);

  localparam int BPB = DATA_W / 8;
  localparam int HB  = 256 / DATA_W;
  localparam int SH  = $clog2(BPB);
  localparam logic [2:0]     HB_LAST  = 3'(HB - 1);
  localparam logic [BPB-1:0] KEEP_ALL = '1;

  // Only the three widths that divide the 256-bit header into whole beats work.
  if (DATA_W != 64 && DATA_W != 128 && DATA_W != 256) begin : g_bad_width
    $error("mpi_eth_pkt_gen: DATA_W must be 64, 128 or 256");
  end

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    PAY,
    DONE
  } state_t;

  state_t         state;
  logic [255:0]   hdr_vec;
  logic [2:0]     hdr_idx;
  logic           size_zero;
  logic [15:0]    pay_total;
  logic [15:0]    pay_cnt;
  logic [BPB-1:0] tail_keep;

  logic           out_fire;
  logic           pay_fire;
  logic           last_pay_beat;
  logic           size_bad;
  logic [255:0]   req_hdr;
  logic [15:0]    req_beats;
  logic [BPB-1:0] req_tail_keep;
  logic           unused_pay_keep;

  // Upstream byte enables carry no information; output KEEP comes from size.
  assign unused_pay_keep = ^pay_KEEP;

  // Header vector as it goes on the wire, most significant byte first.
  assign req_hdr = {mac_dst, mac_src, ip_src, ip_dst, dst, dst_rank,
                    src_rank, packet_type, tag, size, 8'h00};

  // Payload beats are ceil(size / BPB). This is only latched when size is legal,
  // so the truncation to 16 bits cannot lose anything.
  assign req_beats = 16'((size + 32'(BPB - 1)) >> SH);

  // The tail beat keeps the low (size mod BPB) bytes. A zero remainder means
  // the tail beat is full.
  assign req_tail_keep = (size[SH-1:0] == '0) ? KEEP_ALL
                                              : ~(KEEP_ALL << size[SH-1:0]);

  assign size_bad      = size > 32'(MAX_BYTES);
  assign out_fire      = stream_out_VALID && stream_out_READY;
  assign last_pay_beat = (pay_cnt + 16'd1) == pay_total;

  // The output register is a one-entry stage. It can take a new payload beat
  // whenever it is empty or is being drained this cycle. No beats are taken
  // once the size count has been reached, so extra upstream beats are held off.
  assign pay_READY = (state == PAY) && (pay_cnt != pay_total) &&
                     (!stream_out_VALID || stream_out_READY);
  assign pay_fire  = pay_VALID && pay_READY;

  // Select header beat k. Beat 0 is the most significant slice of the vector.
  function automatic logic [DATA_W-1:0] hdr_beat(input logic [255:0] h,
                                                 input logic [2:0]   k);
    return DATA_W'(h >> (256 - (int'(k) + 1) * DATA_W));
  endfunction

  // Main control. One registered FSM owns every output register.
  // The output beat register only changes when it is empty or its current
  // beat transfers, so DATA/KEEP/LAST hold steady while the consumer stalls.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state            <= IDLE;
      hdr_ready        <= 1'b1;
      stream_out_VALID <= 1'b0;
      stream_out_LAST  <= 1'b0;
      stream_out_DATA  <= '0;
      stream_out_KEEP  <= '0;
      err_size         <= 1'b0;
      err_len          <= 1'b0;
      pkt_count        <= '0;
      hdr_vec          <= '0;
      hdr_idx          <= '0;
      size_zero        <= 1'b0;
      pay_total        <= '0;
      pay_cnt          <= '0;
      tail_keep        <= '0;
    end else begin
      err_size <= 1'b0;
      err_len  <= 1'b0;
      case (state)
        IDLE: begin
          if (hdr_valid && hdr_ready) begin
            if (size_bad) begin
              err_size <= 1'b1;
            end else begin
              hdr_vec          <= req_hdr;
              size_zero        <= (size == 32'd0);
              pay_total        <= req_beats;
              pay_cnt          <= '0;
              tail_keep        <= req_tail_keep;
              hdr_idx          <= '0;
              stream_out_DATA  <= hdr_beat(req_hdr, 3'd0);
              stream_out_KEEP  <= KEEP_ALL;
              stream_out_LAST  <= (HB == 1) && (size == 32'd0);
              stream_out_VALID <= 1'b1;
              hdr_ready        <= 1'b0;
              state            <= HDR;
            end
          end
        end

        HDR: begin
          if (out_fire) begin
            if (hdr_idx == HB_LAST) begin
              stream_out_VALID <= 1'b0;
              stream_out_LAST  <= 1'b0;
              if (size_zero) begin
                pkt_count <= pkt_count + CNT_W'(1);
                state     <= DONE;
              end else begin
                state <= PAY;
              end
            end else begin
              hdr_idx         <= hdr_idx + 3'd1;
              stream_out_DATA <= hdr_beat(hdr_vec, hdr_idx + 3'd1);
              stream_out_LAST <= size_zero && ((hdr_idx + 3'd1) == HB_LAST);
            end
          end
        end

        PAY: begin
          if (pay_fire) begin
            stream_out_DATA  <= pay_DATA;
            stream_out_KEEP  <= last_pay_beat ? tail_keep : KEEP_ALL;
            stream_out_LAST  <= last_pay_beat;
            stream_out_VALID <= 1'b1;
            pay_cnt          <= pay_cnt + 16'd1;
            err_len          <= (pay_LAST != last_pay_beat);
          end else if (out_fire) begin
            stream_out_VALID <= 1'b0;
            stream_out_LAST  <= 1'b0;
            if (stream_out_LAST) begin
              pkt_count <= pkt_count + CNT_W'(1);
              state     <= DONE;
            end
          end
        end

        DONE: begin
          hdr_ready <= 1'b1;
          state     <= IDLE;
        end

        default: begin
          hdr_ready <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mpi_eth_pkt_gen.sv
// -----------------------------------------------------------------------------
// tb_mpi_eth_pkt_gen
//
// Testbench for mpi_eth_pkt_gen. It drives a 64-bit instance with directed
// and randomized packets, and a 256-bit instance with directed packets.
// Output beats are compared against a byte-level reference model of the
// packet format.
// -----------------------------------------------------------------------------
module tb_mpi_eth_pkt_gen;

  localparam int W    = 64;
  localparam int B    = W / 8;
  localparam int W2   = 256;
  localparam int B2   = W2 / 8;
  localparam int MAXB = 9000;

  typedef struct {
    logic [255:0] data;
    logic [31:0]  keep;
    logic         last;
  } beat_t;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  // Header fields are shared by both instances.
  logic [47:0] mac_dst, mac_src;
  logic [31:0] ip_src, ip_dst;
  logic [15:0] dst, dst_rank;
  logic [7:0]  src_rank, packet_type, tag;
  logic [31:0] size;

  // 64-bit instance
  logic         hdr_valid, hdr_ready;
  logic [W-1:0] pay_data;
  logic [B-1:0] pay_keep;
  logic         pay_last, pay_valid, pay_ready;
  logic [W-1:0] out_data;
  logic [B-1:0] out_keep;
  logic         out_last, out_valid, out_ready;
  logic         err_size, err_len;
  logic [31:0]  pkt_count;

  // 256-bit instance
  logic          w_hdr_valid, w_hdr_ready;
  logic [W2-1:0] w_pay_data;
  logic [B2-1:0] w_pay_keep;
  logic          w_pay_last, w_pay_valid, w_pay_ready;
  logic [W2-1:0] w_out_data;
  logic [B2-1:0] w_out_keep;
  logic          w_out_last, w_out_valid, w_out_ready;
  logic          w_err_size, w_err_len;
  logic [31:0]   w_pkt_count;

  int errors = 0;
  int checks = 0;
  int exp_pkts = 0;
  int w_pkts = 0;

  logic [255:0] pay_q[$];
  beat_t        exp_q[$];
  beat_t        got_q[$];

  mpi_eth_pkt_gen #(.DATA_W(W), .MAX_BYTES(MAXB), .CNT_W(32)) dut (
    .clk(clk), .resetn(resetn),
    .hdr_valid(hdr_valid), .hdr_ready(hdr_ready),
    .mac_dst(mac_dst), .mac_src(mac_src), .ip_src(ip_src), .ip_dst(ip_dst),
    .dst(dst), .dst_rank(dst_rank), .src_rank(src_rank),
    .packet_type(packet_type), .tag(tag), .size(size),
    .pay_DATA(pay_data), .pay_KEEP(pay_keep), .pay_LAST(pay_last),
    .pay_VALID(pay_valid), .pay_READY(pay_ready),
    .stream_out_DATA(out_data), .stream_out_KEEP(out_keep),
    .stream_out_LAST(out_last), .stream_out_VALID(out_valid),
    .stream_out_READY(out_ready),
    .err_size(err_size), .err_len(err_len), .pkt_count(pkt_count)
  );

  mpi_eth_pkt_gen #(.DATA_W(W2), .MAX_BYTES(MAXB), .CNT_W(32)) dut_wide (
    .clk(clk), .resetn(resetn),
    .hdr_valid(w_hdr_valid), .hdr_ready(w_hdr_ready),
    .mac_dst(mac_dst), .mac_src(mac_src), .ip_src(ip_src), .ip_dst(ip_dst),
    .dst(dst), .dst_rank(dst_rank), .src_rank(src_rank),
    .packet_type(packet_type), .tag(tag), .size(size),
    .pay_DATA(w_pay_data), .pay_KEEP(w_pay_keep), .pay_LAST(w_pay_last),
    .pay_VALID(w_pay_valid), .pay_READY(w_pay_ready),
    .stream_out_DATA(w_out_data), .stream_out_KEEP(w_out_keep),
    .stream_out_LAST(w_out_last), .stream_out_VALID(w_out_valid),
    .stream_out_READY(w_out_ready),
    .err_size(w_err_size), .err_len(w_err_len), .pkt_count(w_pkt_count)
  );

  task automatic checkOutput(input string name, input logic [255:0] got,
                             input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [255:0] model_header();
    return {mac_dst, mac_src, ip_src, ip_dst, dst, dst_rank,
            src_rank, packet_type, tag, size, 8'h00};
  endfunction

  // Reference packet: the header cut into width-sized slices, then payload
  // beats whose byte enables cover exactly the bytes still remaining.
  function automatic void build_expected(input int width);
    beat_t        b;
    int           bpb, nhdr, sz, npay, nbytes;
    logic [255:0] h, dmask;
    bpb   = width / 8;
    nhdr  = 256 / width;
    sz    = int'(size);
    h     = model_header();
    dmask = {256{1'b1}} >> (256 - width);
    npay  = (sz + bpb - 1) / bpb;
    exp_q.delete();
    for (int k = 0; k < nhdr; k++) begin
      b.data = (h >> (256 - (k + 1) * width)) & dmask;
      b.keep = 32'hFFFF_FFFF >> (32 - bpb);
      b.last = (sz == 0) && (k == nhdr - 1);
      exp_q.push_back(b);
    end
    for (int i = 0; i < npay; i++) begin
      nbytes = sz - i * bpb;
      if (nbytes > bpb) nbytes = bpb;
      b.data = pay_q[i] & dmask;
      b.keep = 32'hFFFF_FFFF >> (32 - nbytes);
      b.last = (i == npay - 1);
      exp_q.push_back(b);
    end
  endfunction

  task automatic randomize_fields();
    mac_dst     = 48'({$urandom, $urandom});
    mac_src     = 48'({$urandom, $urandom});
    ip_src      = $urandom;
    ip_dst      = $urandom;
    dst         = 16'($urandom);
    dst_rank    = 16'($urandom);
    src_rank    = 8'($urandom);
    packet_type = 8'($urandom);
    tag         = 8'($urandom);
  endtask

  task automatic compare_beats(input string pfx);
    checkOutput({pfx, "_beats"}, 256'(got_q.size()), 256'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checkOutput($sformatf("%s_b%0d_data", pfx, i), got_q[i].data, exp_q[i].data);
      checkOutput($sformatf("%s_b%0d_keep", pfx, i), 256'(got_q[i].keep), 256'(exp_q[i].keep));
      checkOutput($sformatf("%s_b%0d_last", pfx, i), 256'(got_q[i].last), 256'(exp_q[i].last));
    end
  endtask

  // One packet through the 64-bit instance. bad_beat flips pay_LAST on that
  // payload beat index (-1 for none).
  task automatic applyStimulus(input string pfx, input int sz, input bit rand_ready,
                               input bit rand_gaps, input int bad_beat);
    int           npay, pi, cyc, elen, exp_elen;
    bit           done, stalled;
    logic [W+B:0] held;
    beat_t        b;
    randomize_fields();
    size = 32'(sz);
    npay = (sz + B - 1) / B;
    pay_q.delete();
    for (int i = 0; i < npay; i++) pay_q.push_back(256'({$urandom, $urandom}));
    build_expected(W);
    exp_elen = (bad_beat >= 0 && bad_beat < npay) ? 1 : 0;

    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!hdr_ready && cyc < 20);
    hdr_valid = 1'b1;
    @(negedge clk);
    hdr_valid = 1'b0;

    pi = 0; cyc = 0; elen = 0; done = 1'b0; stalled = 1'b0; held = '0;
    got_q.delete();
    while (!done && cyc < 20000) begin
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (pi < npay) begin
        pay_valid = rand_gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
        pay_data  = pay_q[pi][W-1:0];
        pay_keep  = B'($urandom);
        pay_last  = (pi == npay - 1) ^ (pi == bad_beat);
      end else begin
        pay_valid = 1'b0;
        pay_last  = 1'b0;
      end
      #1;
      if (cyc == 0) checkOutput({pfx, "_hdr_latency"}, 256'(out_valid), 256'(1));
      if (err_len) elen++;
      if (stalled) begin
        checkOutput({pfx, "_hold_valid"}, 256'(out_valid), 256'(1));
        checkOutput({pfx, "_hold_beat"}, 256'({out_data, out_keep, out_last}), 256'(held));
      end
      stalled = out_valid && !out_ready;
      held    = {out_data, out_keep, out_last};
      if (pay_valid && pay_ready) pi++;
      if (out_valid && out_ready) begin
        b.data = 256'(out_data);
        b.keep = 32'(out_keep);
        b.last = out_last;
        got_q.push_back(b);
        if (out_last) done = 1'b1;
      end
      cyc++;
      @(negedge clk);
    end
    pay_valid = 1'b0;
    pay_last  = 1'b0;
    out_ready = 1'b1;
    if (!done) checkOutput({pfx, "_timeout"}, 256'(0), 256'(1));
    compare_beats(pfx);
    checkOutput({pfx, "_err_len_pulses"}, 256'(elen), 256'(exp_elen));
    exp_pkts++;
    checkOutput({pfx, "_pkt_count"}, 256'(pkt_count), 256'(exp_pkts));
  endtask

  // One packet through the 256-bit instance with the consumer always ready.
  task automatic run_wide(input string pfx, input int sz);
    int    npay, pi, cyc;
    bit    done;
    beat_t b;
    randomize_fields();
    size = 32'(sz);
    npay = (sz + B2 - 1) / B2;
    pay_q.delete();
    for (int i = 0; i < npay; i++)
      pay_q.push_back({$urandom, $urandom, $urandom, $urandom,
                       $urandom, $urandom, $urandom, $urandom});
    build_expected(W2);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!w_hdr_ready && cyc < 20);
    w_hdr_valid = 1'b1;
    @(negedge clk);
    w_hdr_valid = 1'b0;
    pi = 0; cyc = 0; done = 1'b0;
    got_q.delete();
    while (!done && cyc < 200) begin
      w_out_ready = 1'b1;
      w_pay_valid = (pi < npay);
      w_pay_data  = (pi < npay) ? pay_q[pi] : '0;
      w_pay_last  = (pi == npay - 1);
      #1;
      if (w_pay_valid && w_pay_ready) pi++;
      if (w_out_valid && w_out_ready) begin
        b.data = w_out_data;
        b.keep = w_out_keep;
        b.last = w_out_last;
        got_q.push_back(b);
        if (w_out_last) done = 1'b1;
      end
      cyc++;
      @(negedge clk);
    end
    w_pay_valid = 1'b0;
    w_pay_last  = 1'b0;
    if (!done) checkOutput({pfx, "_timeout"}, 256'(0), 256'(1));
    compare_beats(pfx);
    w_pkts++;
    checkOutput({pfx, "_pkt_count"}, 256'(w_pkt_count), 256'(w_pkts));
  endtask

  initial begin
    int sz, bad, base;
    resetn = 1'b1;
    hdr_valid = 1'b0; pay_data = '0; pay_keep = '0; pay_last = 1'b0; pay_valid = 1'b0;
    out_ready = 1'b1;
    w_hdr_valid = 1'b0; w_pay_data = '0; w_pay_keep = '0; w_pay_last = 1'b0;
    w_pay_valid = 1'b0; w_out_ready = 1'b1;
    size = '0;
    randomize_fields();
    #2 resetn = 1'b0;
    #10;
    checkOutput("rst_hdr_ready", 256'(hdr_ready), 256'(1));
    checkOutput("rst_pay_ready", 256'(pay_ready), 256'(0));
    checkOutput("rst_valid", 256'(out_valid), 256'(0));
    checkOutput("rst_last", 256'(out_last), 256'(0));
    checkOutput("rst_data", 256'(out_data), 256'(0));
    checkOutput("rst_keep", 256'(out_keep), 256'(0));
    checkOutput("rst_errs", 256'({err_size, err_len}), 256'(0));
    checkOutput("rst_pkt_count", 256'(pkt_count), 256'(0));
    checkOutput("rst_wide_hdr_ready", 256'(w_hdr_ready), 256'(1));
    @(negedge clk);
    resetn = 1'b1;

    // Header-only packet.
    applyStimulus("t1", 0, 1'b0, 1'b0, -1);
    if (got_q.size() > 0)
      checkOutput("t1_beat0_direct", got_q[0].data, 256'({mac_dst, mac_src[47:32]}));

    // Two payload beats with a 5-byte tail, then the same size under backpressure.
    applyStimulus("t2", 13, 1'b0, 1'b0, -1);
    if (got_q.size() > 5) begin
      checkOutput("t2_tail_keep", 256'(got_q[5].keep), 256'(8'h1F));
      checkOutput("t2_tail_last", 256'(got_q[5].last), 256'(1));
    end
    applyStimulus("t3", 13, 1'b1, 1'b1, -1);

    // Oversized request is rejected without output.
    randomize_fields();
    size = 32'(MAXB + 1);
    base = exp_pkts;
    @(negedge clk);
    hdr_valid = 1'b1;
    @(negedge clk);
    hdr_valid = 1'b0;
    #1;
    checkOutput("t4_err_size", 256'(err_size), 256'(1));
    checkOutput("t4_no_valid", 256'(out_valid), 256'(0));
    checkOutput("t4_hdr_ready", 256'(hdr_ready), 256'(1));
    @(negedge clk);
    #1;
    checkOutput("t4_err_size_clear", 256'(err_size), 256'(0));
    checkOutput("t4_still_no_valid", 256'(out_valid), 256'(0));
    checkOutput("t4_pkt_count", 256'(pkt_count), 256'(base));

    // Early pay_LAST on the first payload beat.
    applyStimulus("t5", 16, 1'b0, 1'b0, 0);

    // Largest legal payload.
    applyStimulus("tmax", MAXB, 1'b0, 1'b0, -1);

    // Randomized packets.
    for (int n = 0; n < 30; n++) begin
      sz  = $urandom_range(0, 120);
      bad = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : -1;
      applyStimulus($sformatf("r%0d", n), sz, 1'b1, 1'($urandom_range(0, 1)), bad);
    end

    // Wide instance: full header in one beat, one full payload beat; then header-only.
    run_wide("t6", 32);
    if (got_q.size() > 0)
      checkOutput("t6_beat0_is_header", got_q[0].data, model_header());
    run_wide("t6z", 0);
    run_wide("t6r", 45);

    // Reset in the middle of a payload abandons the packet.
    randomize_fields();
    size = 32'd64;
    @(negedge clk);
    hdr_valid = 1'b1;
    @(negedge clk);
    hdr_valid = 1'b0;
    out_ready = 1'b1;
    pay_valid = 1'b1;
    pay_last  = 1'b0;
    pay_data  = {$urandom, $urandom};
    repeat (7) @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    checkOutput("trst_valid", 256'(out_valid), 256'(0));
    checkOutput("trst_last", 256'(out_last), 256'(0));
    checkOutput("trst_data", 256'(out_data), 256'(0));
    checkOutput("trst_keep", 256'(out_keep), 256'(0));
    checkOutput("trst_hdr_ready", 256'(hdr_ready), 256'(1));
    checkOutput("trst_pay_ready", 256'(pay_ready), 256'(0));
    checkOutput("trst_pkt_count", 256'(pkt_count), 256'(0));
    @(negedge clk);
    pay_valid = 1'b0;
    resetn    = 1'b1;
    exp_pkts  = 0;
    w_pkts    = 0;
    applyStimulus("tpost", 24, 1'b1, 1'b0, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
